vx_csr_rmw_stage: RTL and testbench

- Request/commit stage directly upstream of the CSR data store. Accepts CSR instructions (CSRRW/CSRRS/CSRRC and immediate forms) from the issue path.
- Drives the store's read port combinationally and computes the read-modify-write value. Issues a single-cycle registered write to the store's write port.
- Returns the old CSR value to writeback through a valid/ready response register.
- Forwards an in-flight write to a same-address, same-warp read, so back-to-back CSR instructions never observe stale data.

---
 rtl/vx_csr_rmw_stage_pkg.sv | 22 ++
 rtl/vx_csr_alu.sv | 66 ++++++
 rtl/vx_csr_rmw_stage.sv | 152 +++++++++++++++
 tb/tb_vx_csr_rmw_stage.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vx_csr_rmw_stage_pkg.sv
// Shared CSR op encodings, default widths and the read-only address test
// used by the CSR read-modify-write stage.
package vx_csr_rmw_stage_pkg;

   localparam int DEF_NUM_WARPS     = 4;
   localparam int DEF_CSR_ADDR_BITS = 12;
   localparam int DEF_CSR_WIDTH     = 32;
   localparam int DEF_NW_BITS       = (DEF_NUM_WARPS > 1) ? $clog2(DEF_NUM_WARPS) : 1;

   typedef enum logic [1:0] {
      CSR_OP_RW  = 2'b00,
      CSR_OP_RS  = 2'b01,
      CSR_OP_RC  = 2'b10,
      CSR_OP_RSV = 2'b11
   } csr_op_e;

   // Takes the top two address bits; 2'b11 marks the read-only CSR space.
   function automatic logic csr_is_ro(input logic [1:0] addr_top);
      return addr_top == 2'b11;
   endfunction

endpackage

// File: rtl/vx_csr_alu.sv
// Combinational half of the CSR stage: same-warp/same-address forwarding,
// RW/RS/RC value compute and write-suppress / read-only decode.
module vx_csr_alu
   import vx_csr_rmw_stage_pkg::*;
#(
   parameter int CSR_ADDR_BITS = DEF_CSR_ADDR_BITS,
   parameter int CSR_WIDTH     = DEF_CSR_WIDTH,
   parameter int NW_BITS       = DEF_NW_BITS
) (
   input  logic [1:0]               op_i,
   input  logic                     use_imm_i,
   input  logic [4:0]               imm_i,
   input  logic [4:0]               rs1_idx_i,
   input  logic [CSR_WIDTH-1:0]     rs1_data_i,
   input  logic [CSR_ADDR_BITS-1:0] addr_i,
   input  logic [NW_BITS-1:0]       wid_i,
   input  logic [CSR_WIDTH-1:0]     rd_data_i,
   input  logic                     fwd_en_i,
   input  logic [CSR_ADDR_BITS-1:0] fwd_addr_i,
   input  logic [NW_BITS-1:0]       fwd_wid_i,
   input  logic [CSR_WIDTH-1:0]     fwd_data_i,
   output logic [CSR_WIDTH-1:0]     old_o,
   output logic [CSR_WIDTH-1:0]     new_o,
   output logic                     wr_en_o,
   output logic                     illegal_o
);

   logic [CSR_WIDTH-1:0] src;
   logic                 src_nz;
   logic                 fwd_hit;
   logic                 want_write;

   assign src     = use_imm_i ? {{(CSR_WIDTH-5){1'b0}}, imm_i} : rs1_data_i;
   assign src_nz  = use_imm_i ? (imm_i != 5'd0) : (rs1_idx_i != 5'd0);
   // The store only updates at the clock edge, so the write sitting in the
   // output register is newer than anything rd_data can show.
   assign fwd_hit = fwd_en_i & (fwd_addr_i == addr_i) & (fwd_wid_i == wid_i);
   assign old_o   = fwd_hit ? fwd_data_i : rd_data_i;

   always_comb begin
      want_write = 1'b0;
      new_o      = src;
      case (csr_op_e'(op_i))
         CSR_OP_RW: begin
            want_write = 1'b1;
            new_o      = src;
         end
         CSR_OP_RS: begin
            want_write = src_nz;
            new_o      = old_o | src;
         end
         CSR_OP_RC: begin
            want_write = src_nz;
            new_o      = old_o & ~src;
         end
         CSR_OP_RSV: begin
            want_write = 1'b0;
            new_o      = old_o | src;
         end
      endcase
   end

   assign illegal_o = want_write & csr_is_ro(addr_i[CSR_ADDR_BITS-1 -: 2]);
   assign wr_en_o   = want_write & ~illegal_o;

endmodule

// File: rtl/vx_csr_rmw_stage.sv
// CSR request/commit stage: drives the store read port, issues a one-cycle
// registered write and returns the old value through a response register.
module vx_csr_rmw_stage
   import vx_csr_rmw_stage_pkg::*;
#(
   parameter int CORE_ID       = 0,
   parameter int NUM_WARPS     = DEF_NUM_WARPS,
   parameter int CSR_ADDR_BITS = DEF_CSR_ADDR_BITS,
   parameter int CSR_WIDTH     = DEF_CSR_WIDTH,
   parameter int RD_BITS       = 5,
   parameter int NW_BITS       = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic [1:0]               req_op,
   input  logic                     req_use_imm,
   input  logic [4:0]               req_imm,
   input  logic [4:0]               req_rs1_idx,
   input  logic [CSR_WIDTH-1:0]     req_rs1_data,
   input  logic [CSR_ADDR_BITS-1:0] req_addr,
   input  logic [NW_BITS-1:0]       req_wid,
   input  logic [RD_BITS-1:0]       req_rd,
   output logic                     rd_enable,
   output logic [CSR_ADDR_BITS-1:0] rd_addr,
   output logic [NW_BITS-1:0]       rd_wid,
   input  logic [CSR_WIDTH-1:0]     rd_data,
   output logic                     wr_enable,
   output logic [CSR_ADDR_BITS-1:0] wr_addr,
   output logic [NW_BITS-1:0]       wr_wid,
   output logic [CSR_WIDTH-1:0]     wr_data,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [CSR_WIDTH-1:0]     rsp_data,
   output logic [RD_BITS-1:0]       rsp_rd,
   output logic [NW_BITS-1:0]       rsp_wid,
   output logic                     rsp_illegal,
   output logic                     pending
);

   logic                     fire;
   logic [CSR_WIDTH-1:0]     alu_old, alu_new;
   logic                     alu_wr_en, alu_illegal;

   logic                     rsp_valid_q, rsp_valid_d;
   logic [CSR_WIDTH-1:0]     rsp_data_q, rsp_data_d;
   logic [RD_BITS-1:0]       rsp_rd_q, rsp_rd_d;
   logic [NW_BITS-1:0]       rsp_wid_q, rsp_wid_d;
   logic                     rsp_illegal_q, rsp_illegal_d;
   logic                     wr_en_q, wr_en_d;
   logic [CSR_ADDR_BITS-1:0] wr_addr_q, wr_addr_d;
   logic [NW_BITS-1:0]       wr_wid_q, wr_wid_d;
   logic [CSR_WIDTH-1:0]     wr_data_q, wr_data_d;

   assign req_ready = ~rsp_valid_q | rsp_ready;
   assign fire      = req_valid & req_ready;
   assign rd_enable = req_valid;
   assign rd_addr   = req_addr;
   assign rd_wid    = req_wid;

   vx_csr_alu #(
      .CSR_ADDR_BITS (CSR_ADDR_BITS),
      .CSR_WIDTH     (CSR_WIDTH),
      .NW_BITS       (NW_BITS)
   ) u_alu (
      .op_i       (req_op),
      .use_imm_i  (req_use_imm),
      .imm_i      (req_imm),
      .rs1_idx_i  (req_rs1_idx),
      .rs1_data_i (req_rs1_data),
      .addr_i     (req_addr),
      .wid_i      (req_wid),
      .rd_data_i  (rd_data),
      .fwd_en_i   (wr_en_q),
      .fwd_addr_i (wr_addr_q),
      .fwd_wid_i  (wr_wid_q),
      .fwd_data_i (wr_data_q),
      .old_o      (alu_old),
      .new_o      (alu_new),
      .wr_en_o    (alu_wr_en),
      .illegal_o  (alu_illegal)
   );

   // The write pulse depends only on fire, never on rsp_ready, so a stalled
   // response cannot delay or repeat a store update.
   always_comb begin
      rsp_valid_d   = rsp_valid_q;
      rsp_data_d    = rsp_data_q;
      rsp_rd_d      = rsp_rd_q;
      rsp_wid_d     = rsp_wid_q;
      rsp_illegal_d = rsp_illegal_q;
      wr_en_d       = fire & alu_wr_en;
      wr_addr_d     = wr_addr_q;
      wr_wid_d      = wr_wid_q;
      wr_data_d     = wr_data_q;
      if (fire) begin
         rsp_valid_d   = 1'b1;
         rsp_data_d    = alu_old;
         rsp_rd_d      = req_rd;
         rsp_wid_d     = req_wid;
         rsp_illegal_d = alu_illegal;
         wr_addr_d     = req_addr;
         wr_wid_d      = req_wid;
         wr_data_d     = alu_new;
      end else if (rsp_ready) begin
         rsp_valid_d   = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rsp_valid_q   <= 1'b0;
         rsp_data_q    <= '0;
         rsp_rd_q      <= '0;
         rsp_wid_q     <= '0;
         rsp_illegal_q <= 1'b0;
         wr_en_q       <= 1'b0;
         wr_addr_q     <= '0;
         wr_wid_q      <= '0;
         wr_data_q     <= '0;
      end else begin
         rsp_valid_q   <= rsp_valid_d;
         rsp_data_q    <= rsp_data_d;
         rsp_rd_q      <= rsp_rd_d;
         rsp_wid_q     <= rsp_wid_d;
         rsp_illegal_q <= rsp_illegal_d;
         wr_en_q       <= wr_en_d;
         wr_addr_q     <= wr_addr_d;
         wr_wid_q      <= wr_wid_d;
         wr_data_q     <= wr_data_d;
      end
   end

   always_ff @(posedge clk) begin
      if (reset && req_valid)
         assert (req_op != CSR_OP_RSV)
         else $error("core %0d: reserved CSR op 2'b11 issued", CORE_ID);
   end

   assign wr_enable   = wr_en_q;
   assign wr_addr     = wr_addr_q;
   assign wr_wid      = wr_wid_q;
   assign wr_data     = wr_data_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_data    = rsp_data_q;
   assign rsp_rd      = rsp_rd_q;
   assign rsp_wid     = rsp_wid_q;
   assign rsp_illegal = rsp_illegal_q;
   assign pending     = rsp_valid_q | wr_en_q;

endmodule

// File: tb/tb_vx_csr_rmw_stage.sv
// Directed bench for vx_csr_rmw_stage; the bench plays the CSR store by
// driving rd_data with hand-chosen values.
module tb_vx_csr_rmw_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid, req_ready;
   logic [1:0]  req_op;
   logic        req_use_imm;
   logic [4:0]  req_imm, req_rs1_idx;
   logic [31:0] req_rs1_data;
   logic [11:0] req_addr;
   logic [1:0]  req_wid;
   logic [4:0]  req_rd;
   logic        rd_enable;
   logic [11:0] rd_addr;
   logic [1:0]  rd_wid;
   logic [31:0] rd_data;
   logic        wr_enable;
   logic [11:0] wr_addr;
   logic [1:0]  wr_wid;
   logic [31:0] wr_data;
   logic        rsp_valid, rsp_ready;
   logic [31:0] rsp_data;
   logic [4:0]  rsp_rd;
   logic [1:0]  rsp_wid;
   logic        rsp_illegal;
   logic        pending;

   int n_pass = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   vx_csr_rmw_stage dut (
      .clk          (clk),
      .reset        (reset),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_op       (req_op),
      .req_use_imm  (req_use_imm),
      .req_imm      (req_imm),
      .req_rs1_idx  (req_rs1_idx),
      .req_rs1_data (req_rs1_data),
      .req_addr     (req_addr),
      .req_wid      (req_wid),
      .req_rd       (req_rd),
      .rd_enable    (rd_enable),
      .rd_addr      (rd_addr),
      .rd_wid       (rd_wid),
      .rd_data      (rd_data),
      .wr_enable    (wr_enable),
      .wr_addr      (wr_addr),
      .wr_wid       (wr_wid),
      .wr_data      (wr_data),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_data     (rsp_data),
      .rsp_rd       (rsp_rd),
      .rsp_wid      (rsp_wid),
      .rsp_illegal  (rsp_illegal),
      .pending      (pending)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic req(input logic [1:0] op, input logic use_imm, input logic [4:0] imm,
                      input logic [4:0] rs1_idx, input logic [31:0] rs1_data,
                      input logic [11:0] addr, input logic [1:0] wid, input logic [4:0] rd,
                      input logic [31:0] store_val);
      req_valid    = 1'b1;
      req_op       = op;
      req_use_imm  = use_imm;
      req_imm      = imm;
      req_rs1_idx  = rs1_idx;
      req_rs1_data = rs1_data;
      req_addr     = addr;
      req_wid      = wid;
      req_rd       = rd;
      rd_data      = store_val;
   endtask

   task automatic idle();
      req_valid = 1'b0;
      req_op    = 2'b00;
   endtask

   initial begin
      reset = 1'b0;
      rsp_ready = 1'b1;
      rd_data = '0;
      req_use_imm = 1'b0; req_imm = '0; req_rs1_idx = '0; req_rs1_data = '0;
      req_addr = '0; req_wid = '0; req_rd = '0;
      idle();
      #1;
      chk("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      chk("reset_wr_enable", {31'b0, wr_enable}, 32'd0);
      chk("reset_wr_data", wr_data, 32'd0);
      chk("reset_rsp_data", rsp_data, 32'd0);
      chk("reset_pending", {31'b0, pending}, 32'd0);
      tick(); tick();
      reset = 1'b1;
      tick();

      // single RW write
      req(2'b00, 1'b0, 5'd0, 5'd5, 32'hDEADBEEF, 12'h340, 2'd1, 5'd7, 32'h12345678);
      #1;
      chk("rw_req_ready", {31'b0, req_ready}, 32'd1);
      chk("rw_rd_enable", {31'b0, rd_enable}, 32'd1);
      chk("rw_rd_addr", {20'b0, rd_addr}, 32'h340);
      chk("rw_rd_wid", {30'b0, rd_wid}, 32'd1);
      tick();
      idle();
      chk("rw_rsp_valid", {31'b0, rsp_valid}, 32'd1);
      chk("rw_rsp_data", rsp_data, 32'h12345678);
      chk("rw_rsp_rd", {27'b0, rsp_rd}, 32'd7);
      chk("rw_rsp_wid", {30'b0, rsp_wid}, 32'd1);
      chk("rw_wr_enable", {31'b0, wr_enable}, 32'd1);
      chk("rw_wr_addr", {20'b0, wr_addr}, 32'h340);
      chk("rw_wr_wid", {30'b0, wr_wid}, 32'd1);
      chk("rw_wr_data", wr_data, 32'hDEADBEEF);
      chk("rw_illegal", {31'b0, rsp_illegal}, 32'd0);
      chk("rw_pending", {31'b0, pending}, 32'd1);
      tick();
      chk("rw_wr_pulse_end", {31'b0, wr_enable}, 32'd0);
      chk("rw_rsp_cleared", {31'b0, rsp_valid}, 32'd0);
      chk("rw_wr_data_hold", wr_data, 32'hDEADBEEF);
      chk("rw_pending_clr", {31'b0, pending}, 32'd0);

      // RS with rs1=x0 does not write; with rs1=x3 it does
      req(2'b01, 1'b0, 5'd0, 5'd0, 32'h000000FF, 12'h300, 2'd0, 5'd2, 32'h00001200);
      tick();
      req(2'b01, 1'b0, 5'd0, 5'd3, 32'h000000FF, 12'h300, 2'd0, 5'd3, 32'h00001200);
      chk("rs0_rsp_valid", {31'b0, rsp_valid}, 32'd1);
      chk("rs0_rsp_data", rsp_data, 32'h00001200);
      chk("rs0_no_write", {31'b0, wr_enable}, 32'd0);
      tick();
      idle();
      chk("rs3_rsp_data", rsp_data, 32'h00001200);
      chk("rs3_wr_enable", {31'b0, wr_enable}, 32'd1);
      chk("rs3_wr_data", wr_data, 32'h000012FF);
      tick();

      // forwarding: same warp sees in-flight write
      req(2'b00, 1'b0, 5'd0, 5'd1, 32'h0000001F, 12'h001, 2'd0, 5'd4, 32'h00000055);
      tick();
      req(2'b01, 1'b1, 5'd0, 5'd0, 32'h0, 12'h001, 2'd0, 5'd5, 32'h00000055);
      chk("fwd_first_rsp", rsp_data, 32'h00000055);
      chk("fwd_first_wr", wr_data, 32'h0000001F);
      tick();
      idle();
      chk("fwd_same_wid", rsp_data, 32'h0000001F);
      chk("fwd_imm0_no_write", {31'b0, wr_enable}, 32'd0);
      tick();
      // other warp must read the store
      req(2'b00, 1'b0, 5'd0, 5'd1, 32'h0000002A, 12'h001, 2'd0, 5'd4, 32'h00000055);
      tick();
      req(2'b01, 1'b1, 5'd0, 5'd0, 32'h0, 12'h001, 2'd1, 5'd5, 32'h00000077);
      tick();
      idle();
      chk("fwd_other_wid", rsp_data, 32'h00000077);
      tick();

      // backpressure: response stalls, write pulses once
      rsp_ready = 1'b0;
      req(2'b00, 1'b0, 5'd0, 5'd6, 32'hCAFE0001, 12'h305, 2'd2, 5'd9, 32'h11110000);
      tick();
      req(2'b01, 1'b0, 5'd0, 5'd1, 32'h0000000F, 12'h305, 2'd2, 5'd10, 32'hCAFE0001);
      chk("bp_req_ready_c1", {31'b0, req_ready}, 32'd0);
      chk("bp_wr_enable_c1", {31'b0, wr_enable}, 32'd1);
      chk("bp_rsp_data_c1", rsp_data, 32'h11110000);
      tick();
      chk("bp_wr_enable_c2", {31'b0, wr_enable}, 32'd0);
      chk("bp_rsp_valid_c2", {31'b0, rsp_valid}, 32'd1);
      chk("bp_rsp_data_c2", rsp_data, 32'h11110000);
      chk("bp_rsp_rd_c2", {27'b0, rsp_rd}, 32'd9);
      tick();
      chk("bp_wr_enable_c3", {31'b0, wr_enable}, 32'd0);
      chk("bp_rsp_data_c3", rsp_data, 32'h11110000);
      chk("bp_req_ready_c3", {31'b0, req_ready}, 32'd0);
      chk("bp_pending_c3", {31'b0, pending}, 32'd1);
      rsp_ready = 1'b1;
      #1;
      chk("bp_release_ready", {31'b0, req_ready}, 32'd1);
      tick();
      idle();
      chk("bp_next_rsp_valid", {31'b0, rsp_valid}, 32'd1);
      chk("bp_next_rsp_data", rsp_data, 32'hCAFE0001);
      chk("bp_next_rsp_rd", {27'b0, rsp_rd}, 32'd10);
      chk("bp_next_wr_data", wr_data, 32'hCAFE000F);
      chk("bp_next_wr_en", {31'b0, wr_enable}, 32'd1);
      tick();

      // read-only CSR space
      req(2'b00, 1'b0, 5'd0, 5'd2, 32'h00001234, 12'hC00, 2'd0, 5'd1, 32'h00000BAD);
      tick();
      req(2'b01, 1'b1, 5'd0, 5'd0, 32'h0, 12'hC00, 2'd0, 5'd1, 32'h00000BAD);
      chk("ro_illegal", {31'b0, rsp_illegal}, 32'd1);
      chk("ro_no_write", {31'b0, wr_enable}, 32'd0);
      chk("ro_rsp_data", rsp_data, 32'h00000BAD);
      chk("ro_rsp_valid", {31'b0, rsp_valid}, 32'd1);
      tick();
      idle();
      chk("ro_read_legal", {31'b0, rsp_illegal}, 32'd0);
      chk("ro_read_no_write", {31'b0, wr_enable}, 32'd0);
      chk("ro_read_valid", {31'b0, rsp_valid}, 32'd1);
      tick();

      // async reset right after a fire
      req(2'b00, 1'b0, 5'd0, 5'd1, 32'h00000099, 12'h340, 2'd1, 5'd3, 32'h0);
      tick();
      idle();
      chk("ar_pre_valid", {31'b0, rsp_valid}, 32'd1);
      chk("ar_pre_wr", {31'b0, wr_enable}, 32'd1);
      #1 reset = 1'b0;
      #1;
      chk("ar_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      chk("ar_wr_enable", {31'b0, wr_enable}, 32'd0);
      chk("ar_wr_data", wr_data, 32'd0);
      chk("ar_pending", {31'b0, pending}, 32'd0);
      #2 reset = 1'b1;
      tick();
      req(2'b10, 1'b0, 5'd0, 5'd4, 32'h0000000F, 12'h341, 2'd0, 5'd8, 32'h000000FF);
      tick();
      idle();
      chk("ar_rc_rsp_data", rsp_data, 32'h000000FF);
      chk("ar_rc_wr_enable", {31'b0, wr_enable}, 32'd1);
      chk("ar_rc_wr_data", wr_data, 32'h000000F0);
      tick();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
